btn_press_conditioner: RTL and testbench

//   Input stage that feeds the LED/button game core. Synchronises and debounces the raw

---
 rtl/btn_press_conditioner.sv | 132 +++++++++++++
 tb/tb_btn_press_conditioner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_conditioner.sv
// Button input stage: 2-flop synchroniser, per-bit debounce, press pulses,
// one-deep per-button press queue and a valid/ready event port.
module btn_press_conditioner #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned IDX_W           = 2
) (
  input  logic             osc_clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  input  logic             press_ready,
  output logic             overrun
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] rise;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             valid_next;
  logic [IDX_W-1:0] idx_next;
  logic [N_BTN-1:0] clr;
  logic [N_BTN-1:0] pending_next;
  logic             overrun_next;

  logic [IDX_W-1:0] sel_idx;
  logic [N_BTN-1:0] sel_mask;

  // Two-stage synchroniser for the raw asynchronous buttons
  always_ff @(posedge osc_clk) begin
    if (reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge osc_clk) begin
    if (reset_n) begin
      btn_level <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (sync2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_level[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = btn_level & ~level_d;

  // Lowest pending index wins
  always_comb begin
    sel_idx = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
    sel_mask = N_BTN'(1) << sel_idx;
  end

  // Event port next-state; a pulse landing on a bit being handed out re-arms it
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    idx_next   = press_idx;
    clr        = '0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = HOLD;
          valid_next = 1'b1;
          idx_next   = sel_idx;
          clr        = sel_mask;
        end
      end
      HOLD: begin
        valid_next = 1'b1;
        if (press_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    overrun_next = |(rise & pending & ~clr);
    pending_next = (pending & ~clr) | rise;
  end

  always_ff @(posedge osc_clk) begin
    if (reset_n) begin
      state       <= IDLE;
      press_valid <= 1'b0;
      press_idx   <= '0;
      pending     <= '0;
      overrun     <= 1'b0;
      press_pulse <= '0;
      level_d     <= '0;
    end else begin
      state       <= state_next;
      press_valid <= valid_next;
      press_idx   <= idx_next;
      pending     <= pending_next;
      overrun     <= overrun_next;
      press_pulse <= rise;
      level_d     <= btn_level;
    end
  end

endmodule

// File: tb/tb_btn_press_conditioner.sv
// Bench for btn_press_conditioner: table vectors, directed corner sequences and
// random stimulus checked every cycle against a sample-history reference model.
module tb_btn_press_conditioner;

  localparam int N = 4;
  localparam int D = 16;

  logic       osc_clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       press_ready;
  logic       overrun;

  btn_press_conditioner #(.N_BTN(4), .DEBOUNCE_CYCLES(16), .IDX_W(2)) dut (
    .osc_clk(osc_clk), .reset_n(reset_n), .btn(btn), .btn_level(btn_level),
    .press_pulse(press_pulse), .press_valid(press_valid), .press_idx(press_idx),
    .press_ready(press_ready), .overrun(overrun)
  );

  always #5 osc_clk = ~osc_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge osc_clk) cyc <= cyc + 1;

  // Reference model: level flips once the last D synchronised samples all
  // disagree with it and at least D edges have passed since the previous flip.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_pend, m_pulse;
  logic         m_valid, m_ovr;
  logic [1:0]   m_idx;
  logic [D-1:0] m_hist [N];
  int           m_since [N];

  always @(posedge osc_clk) begin : mdl
    logic [N-1:0] seen, rise, clr;
    bit found;
    if (reset_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_d = '0; m_pend = '0; m_pulse = '0;
      m_valid = 1'b0; m_ovr = 1'b0; m_idx = '0;
      for (int b = 0; b < N; b++) begin
        m_hist[b] = '0;
        m_since[b] = 0;
      end
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      rise = m_lvl & ~m_lvl_d;
      m_lvl_d = m_lvl;
      for (int b = 0; b < N; b++) begin
        m_hist[b] = {m_hist[b][D-2:0], seen[b]};
        m_since[b]++;
        if (m_hist[b] == {D{~m_lvl[b]}} && m_since[b] >= D) begin
          m_lvl[b] = ~m_lvl[b];
          m_since[b] = 0;
        end
      end
      m_pulse = rise;
      clr = '0;
      if (!m_valid) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (m_pend[i] && !found) begin
            found = 1'b1;
            m_idx = 2'(i);
            clr[i] = 1'b1;
            m_valid = 1'b1;
          end
        end
      end else if (press_ready) begin
        m_valid = 1'b0;
      end
      m_ovr = |(rise & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | rise;
    end
  end

  always @(negedge osc_clk) begin
    if (chk_en) begin
      total++;
      if (btn_level !== m_lvl || press_pulse !== m_pulse || press_valid !== m_valid ||
          (m_valid && press_idx !== m_idx) || overrun !== m_ovr) begin
        bad++;
        $display("FAIL model t=%0d got lvl=%b pul=%b v=%b idx=%0d ovr=%b exp lvl=%b pul=%b v=%b idx=%0d ovr=%b",
                 cyc, btn_level, press_pulse, press_valid, press_idx, overrun,
                 m_lvl, m_pulse, m_valid, m_idx, m_ovr);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, 32'({btn_level, press_pulse, press_valid, overrun}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge osc_clk); #1;
    reset_n = 1'b1;
    btn = '0;
    @(posedge osc_clk); #1;
    @(posedge osc_clk); #1;
    reset_n = 1'b0;
    @(negedge osc_clk);
    check_all_zero("reset_state");
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge osc_clk);
    #1;
  endtask

  typedef struct packed {
    logic [3:0]      b;
    logic [2:0]      n;
    logic [3:0][1:0] ids;
  } vec_t;

  vec_t vt [5];

  initial begin
    int k, e, j, r, ovr_cnt, ev_cnt;
    bit seen_v, ev;
    logic [1:0] prev_idx;
    bit prev_v, prev_r;

    reset_n = 1'b1;
    btn = '0;
    press_ready = 1'b0;

    vt[0].b = 4'b0001; vt[0].n = 3'd1; vt[0].ids = {2'd0, 2'd0, 2'd0, 2'd0};
    vt[1].b = 4'b1010; vt[1].n = 3'd2; vt[1].ids = {2'd0, 2'd0, 2'd3, 2'd1};
    vt[2].b = 4'b1111; vt[2].n = 3'd4; vt[2].ids = {2'd3, 2'd2, 2'd1, 2'd0};
    vt[3].b = 4'b0100; vt[3].n = 3'd1; vt[3].ids = {2'd0, 2'd0, 2'd0, 2'd2};
    vt[4].b = 4'b0110; vt[4].n = 3'd2; vt[4].ids = {2'd0, 2'd0, 2'd2, 2'd1};

    do_reset();
    chk_en = 1'b1;

    // Table vectors: press held 40 cycles with ready tied high, then release
    for (int v = 0; v < 5; v++) begin
      do_reset();
      press_ready = 1'b1;
      @(posedge osc_clk); #1;
      btn = vt[v].b;
      k = cyc + 1;
      for (int c = 0; c < 40; c++) begin
        @(negedge osc_clk);
        e = cyc;
        j = e - (k + D + 3);
        ev = (j >= 0) && (j % 2 == 0) && (j / 2 < int'(vt[v].n));
        check("vec_level", 32'(btn_level), (e >= k + D + 1) ? 32'(vt[v].b) : 32'd0);
        check("vec_pulse", 32'(press_pulse), (e == k + D + 2) ? 32'(vt[v].b) : 32'd0);
        check("vec_valid", 32'(press_valid), ev ? 32'd1 : 32'd0);
        if (ev) check("vec_idx", 32'(press_idx), 32'(vt[v].ids[j / 2]));
        check("vec_overrun", 32'(overrun), 32'd0);
      end
      @(posedge osc_clk); #1;
      btn = '0;
      for (int c = 0; c < D + 8; c++) begin
        @(negedge osc_clk);
        check("release_quiet", 32'({press_pulse, press_valid}), 32'd0);
      end
      check("release_level", 32'(btn_level), 32'd0);
    end

    // Bouncing button never settles long enough to register
    do_reset();
    press_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge osc_clk); #1;
      if (c % 5 == 0) btn[2] = ~btn[2];
      @(negedge osc_clk);
      check("bounce_quiet", 32'({btn_level, press_pulse, press_valid}), 32'd0);
    end
    btn = '0;
    idle_cycles(D + 6);

    // Stalled consumer: first press held, second queued, third dropped
    do_reset();
    press_ready = 1'b0;
    ovr_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      btn = 4'b0001;
      for (int c = 0; c < 25; c++) begin
        @(negedge osc_clk);
        if (overrun) ovr_cnt++;
        @(posedge osc_clk); #1;
      end
      btn = 4'b0000;
      for (int c = 0; c < 25; c++) begin
        @(negedge osc_clk);
        if (overrun) ovr_cnt++;
        @(posedge osc_clk); #1;
      end
    end
    check("stall_overrun_count", 32'(ovr_cnt), 32'd1);
    @(negedge osc_clk);
    check("stall_valid", 32'(press_valid), 32'd1);
    check("stall_idx", 32'(press_idx), 32'd0);
    @(posedge osc_clk); #1;
    press_ready = 1'b1;
    ev_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge osc_clk);
      if (press_valid && press_ready) ev_cnt++;
    end
    check("stall_events", 32'(ev_cnt), 32'd2);
    check("stall_drain", 32'(press_valid), 32'd0);

    // Reset while an event is outstanding and btn[3] stays held
    do_reset();
    press_ready = 1'b0;
    btn = 4'b1000;
    seen_v = 1'b0;
    for (int c = 0; c < 60 && !seen_v; c++) begin
      @(negedge osc_clk);
      seen_v = press_valid;
    end
    check("midreset_valid_seen", 32'(seen_v), 32'd1);
    @(posedge osc_clk); #1;
    reset_n = 1'b1;
    press_ready = 1'b1;
    @(posedge osc_clk); #1;
    reset_n = 1'b0;
    r = cyc;
    @(negedge osc_clk);
    check_all_zero("midreset_cleared");
    for (int c = 0; c < D + 8; c++) begin
      @(negedge osc_clk);
      e = cyc;
      check("midreset_valid", 32'(press_valid), (e == r + D + 4) ? 32'd1 : 32'd0);
      if (e == r + D + 4) check("midreset_idx", 32'(press_idx), 32'd3);
    end
    btn = '0;
    idle_cycles(D + 6);

    // Random buttons and random ready against the model
    do_reset();
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_idx = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge osc_clk); #1;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 24) == 0) btn[b] = ~btn[b];
      end
      press_ready = ($urandom_range(0, 2) != 0);
      @(negedge osc_clk);
      if (prev_v && !prev_r && press_valid)
        check("idx_stable", 32'(press_idx), 32'(prev_idx));
      prev_v = press_valid;
      prev_r = press_ready;
      prev_idx = press_idx;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
